// File: rtl/decode_pkg.sv
// Shared types, field positions and helpers for the pipelined instruction decoder.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_NOP  = 3'd0,
    FMT_REG  = 3'd1,
    FMT_IMM  = 3'd2,
    FMT_LDST = 3'd3,
    FMT_BRJ  = 3'd4,
    FMT_ILL  = 3'd7
  } fmt_t;

  localparam int OP_ALU = 5;
  localparam int OP_SP  = 4;
  localparam int OP_MEM = 3;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RA_HI  = 20;
  localparam int RA_LO  = 16;
  localparam int RB_HI  = 15;
  localparam int RB_LO  = 11;
  localparam int ALU_HI = 3;
  localparam int ALU_LO = 0;

  localparam int FIELD_AW = 5;
  localparam int IMM_W    = 17;

  // Every immediate form fits a 17-bit signed value; the stage widens it to DATA_W.
  typedef struct packed {
    fmt_t                fmt;
    logic [5:0]          opcode;
    logic [3:0]          aluop;
    logic [FIELD_AW-1:0] rd;
    logic [FIELD_AW-1:0] ra;
    logic [FIELD_AW-1:0] rb;
    logic                ra_en;
    logic                rb_en;
    logic [IMM_W-1:0]    imm;
    logic                illeg;
  } dec_bundle_t;

  function automatic logic [IMM_W-1:0] sext12(input logic [11:0] v);
    return {{(IMM_W-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational classifier: instruction word plus privilege in, decoded bundle out.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]  inst,
  input  logic         priv,
  output dec_bundle_t  bundle
);

  logic [5:0]       o;
  fmt_t             base_fmt;
  logic [IMM_W-1:0] base_imm;
  logic             base_ra_en;
  logic             base_rb_en;
  logic             illeg;

  assign o = inst[OPC_HI:OPC_LO];

  // Format classification from the opcode class bits.
  always_comb begin
    base_fmt   = FMT_ILL;
    base_imm   = 17'd0;
    base_ra_en = 1'b0;
    base_rb_en = 1'b0;
    if (o == 6'b000000) begin
      base_fmt = FMT_NOP;
    end else if (o[OP_ALU] && !o[OP_MEM]) begin
      if (o[0]) begin
        base_fmt = FMT_IMM;
        base_imm = inst[20:4];
      end else begin
        base_fmt   = FMT_REG;
        base_ra_en = 1'b1;
        base_rb_en = 1'b1;
      end
    end else if (!o[OP_ALU] && o[OP_MEM]) begin
      base_fmt   = FMT_LDST;
      base_imm   = {1'b0, inst[15:0]};
      base_ra_en = 1'b1;
    end else if (!o[OP_ALU] && !o[OP_MEM] && o[2]) begin
      base_fmt   = FMT_BRJ;
      base_imm   = sext12(inst[15:4]);
      base_ra_en = 1'b1;
    end else begin
      base_fmt = FMT_ILL;
    end
  end

  assign illeg = (base_fmt == FMT_ILL) || (o[OP_ALU] && o[OP_MEM]) || (o[OP_SP] && !priv);

  // Illegal bundles keep their register fields but lose format, enables and immediate.
  always_comb begin
    bundle.fmt    = illeg ? FMT_ILL : base_fmt;
    bundle.opcode = o;
    bundle.aluop  = (base_fmt == FMT_LDST) ? 4'd0 : inst[ALU_HI:ALU_LO];
    bundle.rd     = inst[RD_HI:RD_LO];
    bundle.ra     = inst[RA_HI:RA_LO];
    bundle.rb     = inst[RB_HI:RB_LO];
    bundle.ra_en  = illeg ? 1'b0 : base_ra_en;
    bundle.rb_en  = illeg ? 1'b0 : base_rb_en;
    bundle.imm    = illeg ? 17'd0 : base_imm;
    bundle.illeg  = illeg;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: classifier, two-entry skid buffer (or single register) and
// saturating illegal-instruction counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 8,
  parameter int SKID_EN = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [31:0]       inst_in,
  input  logic              inst_valid_in,
  output logic              inst_ready_out,
  input  logic              priv_in,
  input  logic              flush_in,
  output logic              dec_valid_out,
  input  logic              dec_ready_in,
  output logic [2:0]        fmt_out,
  output logic [5:0]        opcode_out,
  output logic [3:0]        aluop_out,
  output logic [REG_AW-1:0] reg_dest_out,
  output logic [REG_AW-1:0] reg_a_out,
  output logic [REG_AW-1:0] reg_b_out,
  output logic              reg_a_en_out,
  output logic              reg_b_en_out,
  output logic [DATA_W-1:0] imm_out,
  output logic              illeg_inst_flg_out,
  output logic [CNT_W-1:0]  illeg_count_out
);

  dec_bundle_t      new_b;
  dec_bundle_t      out_b;
  dec_bundle_t      skid_b;
  logic             out_valid;
  logic             skid_valid;
  logic             ready;
  logic             accept;
  logic             out_free;
  logic [CNT_W-1:0] count;

  decode_comb u_comb (
    .inst   (inst_in),
    .priv   (priv_in),
    .bundle (new_b)
  );

  // In single-register mode the registered bit only masks readiness during reset.
  assign inst_ready_out = (SKID_EN != 0) ? ready : (ready && (!out_valid || dec_ready_in));
  assign accept         = inst_valid_in && inst_ready_out && !flush_in;
  assign out_free       = !out_valid || dec_ready_in;

  // Output slot / skid slot sequencing; skid always drains into out before new entries.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_b      <= '0;
      skid_b     <= '0;
      ready      <= 1'b0;
    end else if (flush_in) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      ready      <= 1'b1;
    end else if (out_free) begin
      ready <= 1'b1;
      if (skid_valid) begin
        out_b      <= skid_b;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_b     <= new_b;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_b     <= new_b;
      skid_valid <= 1'b1;
      ready      <= 1'b0;
    end else begin
      ready <= !skid_valid;
    end
  end

  // Saturating count of illegal instructions actually accepted.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      count <= '0;
    end else if (accept && new_b.illeg && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign dec_valid_out      = out_valid;
  assign fmt_out            = out_b.fmt;
  assign opcode_out         = out_b.opcode;
  assign aluop_out          = out_b.aluop;
  assign reg_dest_out       = REG_AW'(out_b.rd);
  assign reg_a_out          = REG_AW'(out_b.ra);
  assign reg_b_out          = REG_AW'(out_b.rb);
  assign reg_a_en_out       = out_b.ra_en;
  assign reg_b_en_out       = out_b.rb_en;
  assign imm_out            = DATA_W'($signed(out_b.imm));
  assign illeg_inst_flg_out = out_b.illeg;
  assign illeg_count_out    = count;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then randomized traffic,
// compared against a queue-based reference model of the stage.
module tb_decode_stage;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] inst_in;
  logic        inst_valid_in;
  logic        inst_ready_out;
  logic        priv_in;
  logic        flush_in;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [2:0]  fmt_out;
  logic [5:0]  opcode_out;
  logic [3:0]  aluop_out;
  logic [4:0]  reg_dest_out;
  logic [4:0]  reg_a_out;
  logic [4:0]  reg_b_out;
  logic        reg_a_en_out;
  logic        reg_b_en_out;
  logic [31:0] imm_out;
  logic        illeg_inst_flg_out;
  logic [7:0]  illeg_count_out;

  int vectors = 0;
  int miscompares = 0;

  decode_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(8), .SKID_EN(1)) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .inst_in            (inst_in),
    .inst_valid_in      (inst_valid_in),
    .inst_ready_out     (inst_ready_out),
    .priv_in            (priv_in),
    .flush_in           (flush_in),
    .dec_valid_out      (dec_valid_out),
    .dec_ready_in       (dec_ready_in),
    .fmt_out            (fmt_out),
    .opcode_out         (opcode_out),
    .aluop_out          (aluop_out),
    .reg_dest_out       (reg_dest_out),
    .reg_a_out          (reg_a_out),
    .reg_b_out          (reg_b_out),
    .reg_a_en_out       (reg_a_en_out),
    .reg_b_en_out       (reg_b_en_out),
    .imm_out            (imm_out),
    .illeg_inst_flg_out (illeg_inst_flg_out),
    .illeg_count_out    (illeg_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          fmt;
    int          opc;
    int          aluop;
    int          rd;
    int          ra;
    int          rb;
    bit          a_en;
    bit          b_en;
    bit          ill;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  int   cnt = 0;
  bit   alive = 1'b0;

  function automatic exp_t model(input logic [31:0] ins, input bit pr);
    exp_t e;
    int   op;
    int   v;
    bit   alu;
    bit   sp;
    bit   mem;
    op      = int'(ins >> 26);
    alu     = ((op / 32) % 2) == 1;
    sp      = ((op / 16) % 2) == 1;
    mem     = ((op / 8) % 2) == 1;
    e.opc   = op;
    e.rd    = int'((ins >> 21) & 32'h1F);
    e.ra    = int'((ins >> 16) & 32'h1F);
    e.rb    = int'((ins >> 11) & 32'h1F);
    e.aluop = int'(ins & 32'hF);
    e.imm   = 32'h0;
    e.a_en  = 1'b0;
    e.b_en  = 1'b0;
    if (op == 0) e.fmt = 0;
    else if (alu && !mem && (op % 2) == 0) begin
      e.fmt = 1; e.a_en = 1'b1; e.b_en = 1'b1;
    end else if (alu && !mem) begin
      e.fmt = 2;
      v = int'((ins >> 4) & 32'h1FFFF);
      if (v >= 65536) v = v - 131072;
      e.imm = 32'(v);
    end else if (!alu && mem) begin
      e.fmt = 3; e.imm = ins & 32'hFFFF; e.aluop = 0; e.a_en = 1'b1;
    end else if (!alu && ((op / 4) % 2) == 1) begin
      e.fmt = 4;
      v = int'((ins >> 4) & 32'hFFF);
      if (v >= 2048) v = v - 4096;
      e.imm = 32'(v); e.a_en = 1'b1;
    end else e.fmt = 7;
    e.ill = (e.fmt == 7) || (alu && mem) || (sp && !pr);
    if (e.ill) begin
      e.fmt = 7; e.a_en = 1'b0; e.b_en = 1'b0; e.imm = 32'h0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    chk("valid", dec_valid_out, q.size() > 0);
    chk("ready", inst_ready_out, alive && q.size() < 2);
    chk("count", illeg_count_out, cnt);
    if (q.size() > 0) begin
      e = q[0];
      chk("fmt", fmt_out, e.fmt);
      chk("opcode", opcode_out, e.opc);
      chk("aluop", aluop_out, e.aluop);
      chk("rd", reg_dest_out, e.rd);
      chk("ra", reg_a_out, e.ra);
      chk("rb", reg_b_out, e.rb);
      chk("a_en", reg_a_en_out, e.a_en);
      chk("b_en", reg_b_en_out, e.b_en);
      chk("imm", imm_out, e.imm);
      chk("illeg", illeg_inst_flg_out, e.ill);
    end
  endtask

  // One clock: check state at the falling edge, drive inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] ins, input bit pr, input bit rdy, input bit fl);
    bit acc;
    exp_t e;
    check_outputs();
    inst_valid_in = v; inst_in = ins; priv_in = pr; dec_ready_in = rdy; flush_in = fl;
    @(posedge clk_in);
    acc = v && alive && (q.size() < 2) && !fl;
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) begin
        e = model(ins, pr);
        q.push_back(e);
        if (e.ill && cnt < 255) cnt++;
      end
    end
    alive = 1'b1;
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 15) == 0) r[31:26] = 6'b000000;
    return r;
  endfunction

  initial begin
    logic [31:0] i_reg, i_imm1, i_imm2, i_priv;
    reset_in = 1'b1; inst_in = 32'h0; inst_valid_in = 1'b0; priv_in = 1'b0;
    flush_in = 1'b0; dec_ready_in = 1'b1;
    #2;
    chk("rst_valid", dec_valid_out, 1'b0);
    chk("rst_ready", inst_ready_out, 1'b0);
    chk("rst_fmt", fmt_out, 3'd0);
    chk("rst_imm", imm_out, 32'h0);
    chk("rst_count", illeg_count_out, 8'd0);
    @(negedge clk_in);
    reset_in = 1'b0;

    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ready_after_rst", inst_ready_out, 1'b1);

    i_reg = {6'b100000, 5'd2, 5'd3, 5'd5, 11'd0};
    step(1'b1, i_reg, 1'b0, 1'b1, 1'b0);
    chk("reg_fmt", fmt_out, 3'd1);
    chk("reg_dest", reg_dest_out, 5'd2);
    chk("reg_a", reg_a_out, 5'd3);
    chk("reg_b", reg_b_out, 5'd5);
    chk("reg_en", {reg_a_en_out, reg_b_en_out, illeg_inst_flg_out}, 3'b110);

    i_imm1 = {6'b100001, 5'd1, 17'h1FFFF, 4'h0};
    i_imm2 = {6'b100001, 5'd1, 17'h0FFFF, 4'h0};
    step(1'b1, i_imm1, 1'b0, 1'b1, 1'b0);
    chk("imm_neg", imm_out, 32'hFFFF_FFFF);
    step(1'b1, i_imm2, 1'b0, 1'b1, 1'b0);
    chk("imm_pos", imm_out, 32'h0000_FFFF);

    i_priv = {6'b010100, 26'h0ABCDEF};
    step(1'b1, i_priv, 1'b0, 1'b1, 1'b0);
    chk("priv_user_ill", illeg_inst_flg_out, 1'b1);
    chk("priv_user_fmt", fmt_out, 3'd7);
    chk("priv_user_cnt", illeg_count_out, 8'd1);
    step(1'b1, i_priv, 1'b1, 1'b1, 1'b0);
    chk("priv_sup_ill", illeg_inst_flg_out, 1'b0);

    step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0);
    chk("bp_full_ready", inst_ready_out, 1'b0);
    step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_inst(), 1'b1, 1'b0, 1'b0);
    chk("fl_full_ready", inst_ready_out, 1'b0);
    step(1'b1, i_reg, 1'b1, 1'b0, 1'b1);
    chk("fl_valid", dec_valid_out, 1'b0);
    chk("fl_ready", inst_ready_out, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 300; k++) step(1'b1, i_priv, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("sat_count", illeg_count_out, 8'hFF);

    step(1'b1, i_reg, 1'b1, 1'b0, 1'b0);
    step(1'b1, i_imm1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid", dec_valid_out, 1'b1);
    #2 reset_in = 1'b1;
    #1;
    chk("async_valid", dec_valid_out, 1'b0);
    chk("async_count", illeg_count_out, 8'd0);
    chk("async_ready", inst_ready_out, 1'b0);
    q.delete(); cnt = 0; alive = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b0;

    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
